// File: rtl/cp_link_pkg.sv
// Shared link-layer types for the CP transmit framer: flit types, header fields, FSM states.
// Optional checksum flit build: define CP_TX_CHECKSUM_EN.
package cp_link_pkg;

    localparam int DEST_W   = 5;
    localparam int NODE_W   = 5;
    localparam int LEN_W    = 6;
    localparam int WORD_W   = 16;
    localparam int DEST_MSB = 15;
    localparam int DEST_LSB = 11;
    localparam int LEN_MSB  = 5;
    localparam int LEN_LSB  = 0;

    typedef enum logic [1:0] {
        FT_SINGLE = 2'b00,
        FT_HEAD   = 2'b01,
        FT_BODY   = 2'b10,
        FT_TAIL   = 2'b11
    } flit_type_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HEAD = 2'd1,
`ifdef CP_TX_CHECKSUM_EN
        ST_BODY = 2'd2,
        ST_CSUM = 2'd3
`else
        ST_BODY = 2'd2
`endif
    } tx_state_t;

    function automatic logic [WORD_W-1:0] make_head(
        input logic [DEST_W-1:0] dest,
        input logic [NODE_W-1:0] node,
        input logic [LEN_W-1:0]  len
    );
        return {dest, node, len};
    endfunction

endpackage

// File: rtl/cp_tx_fifo.sv
// Synchronous payload FIFO with registered storage; full/empty derived from wrap-bit pointers.
module cp_tx_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW:0]      wr_ptr_r;
    logic [AW:0]      rd_ptr_r;
    logic             do_push_s;
    logic             do_pop_s;

    assign full      = (wr_ptr_r[AW] != rd_ptr_r[AW]) && (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
    assign empty     = (wr_ptr_r == rd_ptr_r);
    assign do_push_s = push && !full;
    assign do_pop_s  = pop && !empty;
    assign rd_data   = mem_r[rd_ptr_r[AW-1:0]];

    // Pointer update; full is judged on the pre-pop state so a push into a full FIFO is refused.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_r <= {(AW+1){1'b0}};
            rd_ptr_r <= {(AW+1){1'b0}};
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
        end
    end

    // Storage write; contents need no reset because the pointers define validity.
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_r[wr_ptr_r[AW-1:0]] <= push_data;
        end
    end

endmodule

// File: rtl/cp_tx_framer.sv
// Frames GPP header/payload words into link flits (SINGLE/HEAD/BODY/TAIL) with a payload FIFO.
// Define CP_TX_CHECKSUM_EN to append an XOR checksum TAIL flit to every packet.
module cp_tx_framer
    import cp_link_pkg::*;
#(
    parameter int                DEPTH   = 16,
    parameter logic [NODE_W-1:0] NODE_ID = 5'd3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [WORD_W-1:0] gpp_tx_data,
    input  logic              gpp_trf_dp,
    output logic              gpp_trf_cp,
    output logic              tx_overflow,
    output logic              link_valid,
    output logic [1:0]        link_type,
    output logic [WORD_W-1:0] link_data,
    input  logic              link_ready
);

    tx_state_t          state_r;
    logic [DEST_W-1:0]  dest_r;
    logic [LEN_W-1:0]   len_r;
    logic [LEN_W-1:0]   wr_cnt_r;
    logic [LEN_W-1:0]   rd_cnt_r;
    logic               trf_cp_r;
    logic               overflow_r;
`ifdef CP_TX_CHECKSUM_EN
    logic [WORD_W-1:0]  csum_r;
`endif

    logic               fifo_full_s;
    logic               fifo_empty_s;
    logic [WORD_W-1:0]  fifo_head_s;
    logic               push_req_s;
    logic               push_ok_s;
    logic               drop_s;
    logic               hs_s;
    logic               pop_s;
    logic               last_payload_s;
    logic               valid_s;
    flit_type_t         type_s;
    logic [WORD_W-1:0]  data_s;

    cp_tx_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (WORD_W)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push_ok_s),
        .push_data (gpp_tx_data),
        .pop       (pop_s),
        .rd_data   (fifo_head_s),
        .full      (fifo_full_s),
        .empty     (fifo_empty_s)
    );

    // Payload is only accepted once a header is held; the word budget is the header's len.
    assign push_req_s     = gpp_trf_dp && (state_r != ST_IDLE);
    assign push_ok_s      = push_req_s && !fifo_full_s && (wr_cnt_r != len_r);
    assign drop_s         = push_req_s && !push_ok_s;
    assign last_payload_s = (rd_cnt_r == (len_r - 6'd1));
    assign hs_s           = link_valid && link_ready;
    assign pop_s          = hs_s && (state_r == ST_BODY);

    // Flit decode from registered state only; nothing from gpp_tx_data reaches the link directly.
    always_comb begin
        valid_s = 1'b0;
        type_s  = FT_SINGLE;
        data_s  = 16'h0000;
        case (state_r)
            ST_HEAD: begin
                valid_s = 1'b1;
                data_s  = make_head(dest_r, NODE_ID, len_r);
`ifdef CP_TX_CHECKSUM_EN
                type_s  = FT_HEAD;
`else
                if (len_r == 6'd0) begin
                    type_s = FT_SINGLE;
                end else begin
                    type_s = FT_HEAD;
                end
`endif
            end
            ST_BODY: begin
                valid_s = !fifo_empty_s;
                data_s  = fifo_head_s;
`ifdef CP_TX_CHECKSUM_EN
                type_s  = FT_BODY;
`else
                if (last_payload_s) begin
                    type_s = FT_TAIL;
                end else begin
                    type_s = FT_BODY;
                end
`endif
            end
`ifdef CP_TX_CHECKSUM_EN
            ST_CSUM: begin
                valid_s = 1'b1;
                type_s  = FT_TAIL;
                data_s  = csum_r;
            end
`endif
            default: begin
                valid_s = 1'b0;
                type_s  = FT_SINGLE;
                data_s  = 16'h0000;
            end
        endcase
    end

    // Reset kills the link immediately, including the cycle in which it is first sampled.
    assign link_valid  = rst && valid_s;
    assign link_type   = link_valid ? type_s : FT_SINGLE;
    assign link_data   = link_valid ? data_s : 16'h0000;
    assign gpp_trf_cp  = trf_cp_r;
    assign tx_overflow = overflow_r;

    // Packet FSM, counters, sticky overflow and completion flag.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r    <= ST_IDLE;
            dest_r     <= 5'd0;
            len_r      <= 6'd0;
            wr_cnt_r   <= 6'd0;
            rd_cnt_r   <= 6'd0;
            trf_cp_r   <= 1'b1;
            overflow_r <= 1'b0;
`ifdef CP_TX_CHECKSUM_EN
            csum_r     <= 16'h0000;
`endif
        end else begin
            if (drop_s) begin
                overflow_r <= 1'b1;
            end
            if (push_ok_s) begin
                wr_cnt_r <= wr_cnt_r + 6'd1;
`ifdef CP_TX_CHECKSUM_EN
                csum_r   <= csum_r ^ gpp_tx_data;
`endif
            end
            case (state_r)
                ST_IDLE: begin
                    if (gpp_trf_dp) begin
                        dest_r   <= gpp_tx_data[DEST_MSB:DEST_LSB];
                        len_r    <= gpp_tx_data[LEN_MSB:LEN_LSB];
                        wr_cnt_r <= 6'd0;
                        rd_cnt_r <= 6'd0;
`ifdef CP_TX_CHECKSUM_EN
                        csum_r   <= 16'h0000;
`endif
                        trf_cp_r <= 1'b0;
                        state_r  <= ST_HEAD;
                    end
                end
                ST_HEAD: begin
                    if (hs_s) begin
                        if (len_r == 6'd0) begin
`ifdef CP_TX_CHECKSUM_EN
                            state_r  <= ST_CSUM;
`else
                            state_r  <= ST_IDLE;
                            trf_cp_r <= 1'b1;
`endif
                        end else begin
                            state_r <= ST_BODY;
                        end
                    end
                end
                ST_BODY: begin
                    if (pop_s) begin
                        rd_cnt_r <= rd_cnt_r + 6'd1;
                        if (last_payload_s) begin
`ifdef CP_TX_CHECKSUM_EN
                            state_r  <= ST_CSUM;
`else
                            state_r  <= ST_IDLE;
                            trf_cp_r <= 1'b1;
`endif
                        end
                    end
                end
`ifdef CP_TX_CHECKSUM_EN
                ST_CSUM: begin
                    if (hs_s) begin
                        state_r  <= ST_IDLE;
                        trf_cp_r <= 1'b1;
                    end
                end
`endif
                default: begin
                    state_r  <= ST_IDLE;
                    trf_cp_r <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cp_tx_framer.sv
// Directed bench for cp_tx_framer; expectations follow CP_TX_CHECKSUM_EN when it is defined.
module tb_cp_tx_framer;

    logic        clk;
    logic        rst;
    logic [15:0] gpp_tx_data;
    logic        gpp_trf_dp;
    logic        gpp_trf_cp;
    logic        tx_overflow;
    logic        link_valid;
    logic [1:0]  link_type;
    logic [15:0] link_data;
    logic        link_ready;

    int n_assert = 0;
    int n_fail   = 0;

    localparam logic [15:0] T_SINGLE = 16'd0;
    localparam logic [15:0] T_HEAD   = 16'd1;
    localparam logic [15:0] T_BODY   = 16'd2;
    localparam logic [15:0] T_TAIL   = 16'd3;

    cp_tx_framer #(
        .DEPTH   (16),
        .NODE_ID (5'd3)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .gpp_tx_data (gpp_tx_data),
        .gpp_trf_dp  (gpp_trf_dp),
        .gpp_trf_cp  (gpp_trf_cp),
        .tx_overflow (tx_overflow),
        .link_valid  (link_valid),
        .link_type   (link_type),
        .link_data   (link_data),
        .link_ready  (link_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic expect_flit(input string tag, input logic [15:0] typ, input logic [15:0] data);
        chk({tag, "_valid"}, 16'(link_valid), 16'd1);
        chk({tag, "_type"}, 16'(link_type), typ);
        chk({tag, "_data"}, link_data, data);
    endtask

    task automatic expect_idle(input string tag);
        chk({tag, "_valid"}, 16'(link_valid), 16'd0);
        chk({tag, "_trf_cp"}, 16'(gpp_trf_cp), 16'd1);
    endtask

    initial begin
        rst         = 1'b0;
        gpp_tx_data = 16'h0000;
        gpp_trf_dp  = 1'b0;
        link_ready  = 1'b0;
        tick();
        tick();
        chk("rst_valid", 16'(link_valid), 16'd0);
        chk("rst_type", 16'(link_type), 16'd0);
        chk("rst_data", link_data, 16'h0000);
        chk("rst_trf_cp", 16'(gpp_trf_cp), 16'd1);
        chk("rst_ovf", 16'(tx_overflow), 16'd0);
        rst = 1'b1;
        tick();

        // Test 1: three-word packet, ready held high
        link_ready = 1'b1;
        gpp_trf_dp = 1'b1;
        gpp_tx_data = 16'h5003;
        tick();
        expect_flit("t1_head", T_HEAD, 16'h50C3);
        chk("t1_cp_head", 16'(gpp_trf_cp), 16'd0);
        gpp_tx_data = 16'hAAAA;
        tick();
        expect_flit("t1_b0", T_BODY, 16'hAAAA);
        gpp_tx_data = 16'h0F0F;
        tick();
        expect_flit("t1_b1", T_BODY, 16'h0F0F);
        gpp_tx_data = 16'h1234;
        tick();
        gpp_trf_dp = 1'b0;
`ifdef CP_TX_CHECKSUM_EN
        expect_flit("t1_b2", T_BODY, 16'h1234);
        tick();
        expect_flit("t1_csum", T_TAIL, 16'hB791);
`else
        expect_flit("t1_tail", T_TAIL, 16'h1234);
`endif
        chk("t1_cp_tail", 16'(gpp_trf_cp), 16'd0);
        tick();
        expect_idle("t1_end");

        // Test 2: zero-length packet
        gpp_trf_dp = 1'b1;
        gpp_tx_data = 16'h2000;
        tick();
        gpp_trf_dp = 1'b0;
`ifdef CP_TX_CHECKSUM_EN
        expect_flit("t2_head", T_HEAD, 16'h20C0);
        tick();
        expect_flit("t2_csum", T_TAIL, 16'h0000);
`else
        expect_flit("t2_single", T_SINGLE, 16'h20C0);
`endif
        tick();
        expect_idle("t2_end");

        // Test 3: five-cycle stall mid-BODY
        gpp_trf_dp = 1'b1;
        gpp_tx_data = 16'h5003;
        tick();
        expect_flit("t3_head", T_HEAD, 16'h50C3);
        gpp_tx_data = 16'h1111;
        tick();
        expect_flit("t3_b0", T_BODY, 16'h1111);
        link_ready = 1'b0;
        gpp_tx_data = 16'h2222;
        tick();
        for (int i = 0; i < 5; i++) begin
            expect_flit("t3_stall", T_BODY, 16'h1111);
            if (i == 0) begin
                gpp_tx_data = 16'h3333;
            end else begin
                gpp_trf_dp = 1'b0;
            end
            tick();
        end
        link_ready = 1'b1;
        expect_flit("t3_rel", T_BODY, 16'h1111);
        tick();
        expect_flit("t3_b1", T_BODY, 16'h2222);
        tick();
`ifdef CP_TX_CHECKSUM_EN
        expect_flit("t3_b2", T_BODY, 16'h3333);
        tick();
        expect_flit("t3_csum", T_TAIL, 16'h0000);
`else
        expect_flit("t3_tail", T_TAIL, 16'h3333);
`endif
        tick();
        expect_idle("t3_end");
        chk("t3_ovf", 16'(tx_overflow), 16'd0);

        // Test 4: len=20 into a 16-deep FIFO with the link stalled
        link_ready = 1'b0;
        gpp_trf_dp = 1'b1;
        gpp_tx_data = 16'h0814;
        tick();
        for (int i = 0; i < 20; i++) begin
            if (i == 16) begin
                chk("t4_ovf_before", 16'(tx_overflow), 16'd0);
            end
            gpp_tx_data = 16'h0101 + 16'(i);
            tick();
        end
        gpp_trf_dp = 1'b0;
        chk("t4_ovf", 16'(tx_overflow), 16'd1);
        expect_flit("t4_head", T_HEAD, 16'h08D4);
        link_ready = 1'b1;
        tick();
        for (int i = 0; i < 16; i++) begin
            expect_flit("t4_drain", T_BODY, 16'h0101 + 16'(i));
            tick();
        end
        chk("t4_empty", 16'(link_valid), 16'd0);
        chk("t4_cp", 16'(gpp_trf_cp), 16'd0);
        rst = 1'b0;
        tick();
        rst = 1'b1;
        chk("t4_ovf_clr", 16'(tx_overflow), 16'd0);
        expect_idle("t4_rst");

        // Test 5: len=2 with an extra payload write
        link_ready = 1'b0;
        gpp_trf_dp = 1'b1;
        gpp_tx_data = 16'h1802;
        tick();
        gpp_tx_data = 16'hBEEF;
        tick();
        gpp_tx_data = 16'hCAFE;
        tick();
        chk("t5_ovf_before", 16'(tx_overflow), 16'd0);
        gpp_tx_data = 16'hDEAD;
        tick();
        gpp_trf_dp = 1'b0;
        chk("t5_ovf", 16'(tx_overflow), 16'd1);
        expect_flit("t5_head", T_HEAD, 16'h18C2);
        link_ready = 1'b1;
        tick();
        expect_flit("t5_b0", T_BODY, 16'hBEEF);
        tick();
`ifdef CP_TX_CHECKSUM_EN
        expect_flit("t5_b1", T_BODY, 16'hCAFE);
        tick();
        expect_flit("t5_csum", T_TAIL, 16'h7411);
`else
        expect_flit("t5_tail", T_TAIL, 16'hCAFE);
`endif
        tick();
        expect_idle("t5_end");

        // Test 6: reset during BODY, then a fresh packet
        gpp_trf_dp = 1'b1;
        gpp_tx_data = 16'h5003;
        tick();
        expect_flit("t6_head", T_HEAD, 16'h50C3);
        gpp_tx_data = 16'hAAAA;
        tick();
        expect_flit("t6_b0", T_BODY, 16'hAAAA);
        gpp_trf_dp = 1'b0;
        link_ready = 1'b0;
        rst = 1'b0;
        #1;
        chk("t6_valid_in_rst", 16'(link_valid), 16'd0);
        tick();
        rst = 1'b1;
        expect_idle("t6_after_rst");
        chk("t6_ovf_clr", 16'(tx_overflow), 16'd0);
        link_ready = 1'b1;
        gpp_trf_dp = 1'b1;
        gpp_tx_data = 16'h2001;
        tick();
        expect_flit("t6_head2", T_HEAD, 16'h20C1);
        gpp_tx_data = 16'h7777;
        tick();
        gpp_trf_dp = 1'b0;
`ifdef CP_TX_CHECKSUM_EN
        expect_flit("t6_b", T_BODY, 16'h7777);
        tick();
        expect_flit("t6_csum", T_TAIL, 16'h7777);
`else
        expect_flit("t6_tail", T_TAIL, 16'h7777);
`endif
        tick();
        expect_idle("t6_end");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
